// File: rtl/gfx_pattern_gen.sv
// Raster test-pattern generator: streams one frame of pixel beats per start request
// over a valid/ready interface, in solid, colour-bar, checker or gradient mode.
module gfx_pattern_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned H_WIDTH     = 12,
  parameter int unsigned V_WIDTH     = 12,
  parameter int unsigned COLOR_WIDTH = 4,
  parameter int unsigned BAR_WIDTH   = 80,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [3*COLOR_WIDTH-1:0]   fg_color,
  output logic                       m_gfx_valid,
  input  logic                       m_gfx_ready,
  output logic [H_WIDTH-1:0]         m_gfx_x,
  output logic [V_WIDTH-1:0]         m_gfx_y,
  output logic [3*COLOR_WIDTH-1:0]   m_gfx_color,
  output logic                       busy,
  output logic                       done,
  output logic [COLOR_WIDTH-1:0]     frame_cnt
);

  localparam int unsigned CW  = COLOR_WIDTH;
  localparam int unsigned PW  = 3 * COLOR_WIDTH;
  localparam int unsigned BCW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

  localparam logic [H_WIDTH-1:0] X_LAST   = H_WIDTH'(H_VISIBLE - 1);
  localparam logic [V_WIDTH-1:0] Y_LAST   = V_WIDTH'(V_VISIBLE - 1);
  localparam logic [BCW-1:0]     BAR_LAST = BCW'(BAR_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [1:0]           r_mode;
  logic [PW-1:0]        r_fg;
  logic [H_WIDTH-1:0]   r_x;
  logic [V_WIDTH-1:0]   r_y;
  logic [BCW-1:0]       r_bar_cnt;
  logic [2:0]           r_bar_idx;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic [CW-1:0]        r_frame_cnt;

  logic                 w_accept;
  logic                 w_x_last;
  logic                 w_y_last;
  logic                 w_check;
  logic [PW-1:0]        w_color;

  assign w_accept = r_valid && m_gfx_ready;
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  assign w_check  = r_x[CHECK_SHIFT] ^ r_y[CHECK_SHIFT];

  // Frame sequencing and raster walk; bar index tracks columns without a divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_fg        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_bar_cnt   <= '0;
      r_bar_idx   <= 3'd0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= S_RUN;
            r_mode    <= mode;
            r_fg      <= fg_color;
            r_x       <= '0;
            r_y       <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= 3'd0;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_x_last) begin
              r_x       <= '0;
              r_bar_cnt <= '0;
              r_bar_idx <= 3'd0;
              if (w_y_last) begin
                r_y         <= '0;
                r_valid     <= 1'b0;
                r_done      <= 1'b1;
                r_frame_cnt <= r_frame_cnt + CW'(1);
                r_state     <= S_DONE;
              end else begin
                r_y <= r_y + V_WIDTH'(1);
              end
            end else begin
              r_x <= r_x + H_WIDTH'(1);
              if (r_bar_cnt == BAR_LAST) begin
                r_bar_cnt <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
              end else begin
                r_bar_cnt <= r_bar_cnt + BCW'(1);
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel colour is a pure function of the current coordinate and latched frame state.
  always_comb begin
    w_color = '0;
    case (r_mode)
      2'd0: w_color = r_fg;
      2'd1: w_color = {{CW{r_bar_idx[2]}}, {CW{r_bar_idx[1]}}, {CW{r_bar_idx[0]}}};
      2'd2: w_color = w_check ? r_fg : '0;
      2'd3: w_color = {CW'(r_x[CW-1:0] + r_frame_cnt), r_y[CW-1:0], r_frame_cnt};
      default: w_color = '0;
    endcase
  end

  assign m_gfx_valid = r_valid;
  assign m_gfx_x     = r_x;
  assign m_gfx_y     = r_y;
  assign m_gfx_color = w_color;
  assign busy        = r_busy;
  assign done        = r_done;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Directed bench for gfx_pattern_gen on a small 8x4 raster with immediate-assertion checks.
module tb_gfx_pattern_gen;

  localparam int unsigned HV = 8;
  localparam int unsigned VV = 4;
  localparam int unsigned HW = 12;
  localparam int unsigned VW = 12;
  localparam int unsigned CW = 4;
  localparam int unsigned NPIX = HV * VV;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      mode;
  logic [3*CW-1:0] fg_color;
  logic            m_gfx_valid;
  logic            m_gfx_ready;
  logic [HW-1:0]   m_gfx_x;
  logic [VW-1:0]   m_gfx_y;
  logic [3*CW-1:0] m_gfx_color;
  logic            busy;
  logic            done;
  logic [CW-1:0]   frame_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] bars [8];

  always #5 clk = ~clk;

  gfx_pattern_gen #(
    .H_VISIBLE(HV), .V_VISIBLE(VV), .H_WIDTH(HW), .V_WIDTH(VW),
    .COLOR_WIDTH(CW), .BAR_WIDTH(1), .CHECK_SHIFT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .fg_color(fg_color),
    .m_gfx_valid(m_gfx_valid), .m_gfx_ready(m_gfx_ready),
    .m_gfx_x(m_gfx_x), .m_gfx_y(m_gfx_y), .m_gfx_color(m_gfx_color),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] obs_beat();
    return 64'({m_gfx_valid, m_gfx_x, m_gfx_y, m_gfx_color});
  endfunction

  function automatic logic [63:0] exp_beat(input int x, input int y, input logic [11:0] c);
    return 64'({1'b1, 12'(x), 12'(y), c});
  endfunction

  // Start a frame, then scramble the inputs so only latched values can be used.
  task automatic do_start(input logic [1:0] m, input logic [11:0] fg);
    mode     = m;
    fg_color = fg;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    mode     = ~m;
    fg_color = ~fg;
  endtask

  initial begin
    int k;
    bit seen_done;
    logic [11:0] ec;

    bars[0] = 12'h000; bars[1] = 12'h00F; bars[2] = 12'h0F0; bars[3] = 12'h0FF;
    bars[4] = 12'hF00; bars[5] = 12'hF0F; bars[6] = 12'hFF0; bars[7] = 12'hFFF;

    rst_n       = 1'b0;
    start       = 1'b0;
    mode        = 2'd0;
    fg_color    = 12'h000;
    m_gfx_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", 64'({m_gfx_valid, busy, done, frame_cnt, m_gfx_x, m_gfx_y, m_gfx_color}), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_start", 64'({m_gfx_valid, busy}), 64'd0);

    // Solid frame, full throughput
    do_start(2'd0, 12'hF0A);
    for (int i = 0; i < int'(NPIX); i++) begin
      check("solid_beat", obs_beat(), exp_beat(i % HV, i / HV, 12'hF0A));
      tick();
    end
    check("solid_done", 64'({done, m_gfx_valid, busy}), 64'({1'b1, 1'b0, 1'b1}));
    check("solid_frame_cnt", 64'(frame_cnt), 64'd1);
    tick();
    check("solid_idle", 64'({done, m_gfx_valid, busy}), 64'd0);

    // Colour bars
    do_start(2'd1, 12'h123);
    for (int i = 0; i < int'(NPIX); i++) begin
      check("bars_beat", obs_beat(), exp_beat(i % HV, i / HV, bars[i % HV]));
      tick();
    end
    check("bars_done", 64'({done, frame_cnt}), 64'({1'b1, 4'd2}));
    tick();

    // Checker, square size 2
    do_start(2'd2, 12'hFFF);
    for (int i = 0; i < int'(NPIX); i++) begin
      ec = (((i % HV) / 2 + (i / HV) / 2) % 2 == 1) ? 12'hFFF : 12'h000;
      check("checker_beat", obs_beat(), exp_beat(i % HV, i / HV, ec));
      if (i == 2)  check("checker_2_0", 64'(m_gfx_color), 64'h FFF);
      if (i == 16) check("checker_0_2", 64'(m_gfx_color), 64'h FFF);
      if (i == 18) check("checker_2_2", 64'(m_gfx_color), 64'h000);
      tick();
    end
    check("checker_done", 64'({done, frame_cnt}), 64'({1'b1, 4'd3}));
    tick();

    // Random backpressure: every beat must appear in order and hold while stalled
    do_start(2'd0, 12'h123);
    k = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        check("rnd_beat", obs_beat(), exp_beat(k % HV, k / HV, 12'h123));
        m_gfx_ready = 1'($urandom_range(0, 1));
        if (m_gfx_ready) k++;
        tick();
      end
    end
    m_gfx_ready = 1'b1;
    check("rnd_done_seen", 64'(seen_done), 64'd1);
    check("rnd_accepts", 64'(k), 64'(NPIX));
    check("rnd_frame_cnt", 64'(frame_cnt), 64'd4);
    tick();

    // Gradient, two back-to-back frames from a cleared frame counter
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2'd3, 12'h000);
    for (int i = 0; i < int'(NPIX); i++) begin
      check("grad1_beat", obs_beat(), exp_beat(i % HV, i / HV, 12'({4'(i % HV), 4'(i / HV), 4'd0})));
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("grad1_done", 64'({done, frame_cnt}), 64'({1'b1, 4'd1}));
    tick();
    do_start(2'd3, 12'h000);
    for (int i = 0; i < int'(NPIX); i++) begin
      check("grad2_beat", obs_beat(), exp_beat(i % HV, i / HV, 12'({4'(i % HV + 1), 4'(i / HV), 4'd1})));
      if (i == 11) check("grad2_3_1", 64'(m_gfx_color), 64'h411);
      tick();
    end
    check("grad2_done", 64'({done, frame_cnt}), 64'({1'b1, 4'd2}));
    tick();

    // Asynchronous reset mid-frame at beat 10
    do_start(2'd0, 12'hABC);
    for (int i = 0; i < 10; i++) tick();
    check("pre_reset_beat10", obs_beat(), exp_beat(2, 1, 12'hABC));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 64'({m_gfx_valid, busy, done, frame_cnt, m_gfx_x, m_gfx_y, m_gfx_color}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_idle", 64'({m_gfx_valid, busy}), 64'd0);
    do_start(2'd0, 12'h5A5);
    check("post_reset_first", obs_beat(), exp_beat(0, 0, 12'h5A5));
    tick();
    check("post_reset_second", obs_beat(), exp_beat(1, 0, 12'h5A5));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
